fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset, bits [1:0] treated as 0.
REQ-002 Parameter DEPTH, default 4, instruction queue entries, power of two, minimum 2.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 addr  output  32  fetch address driven to memory read port, registered, always word-aligned.
REQ-006 din  input  32  read data returned by memory.
REQ-007 addrIn  input  32  address echoed by memory alongside din.
REQ-008 readValid  input  1  memory asserts when din/addrIn are valid.
REQ-009 memReady  input  1  memory able to service a request this cycle.
REQ-010 redirect  input  1  one-cycle pulse: flush and restart fetch at redirectPc.
REQ-011 redirectPc  input  32  new fetch address, bits [1:0] ignored.
REQ-012 instValid  output  1  queue head holds a valid instruction.
REQ-013 instData  output  32  instruction word at queue head.
REQ-014 instPc  output  32  address of instruction at queue head.
REQ-015 instReady  input  1  consumer accepts head when instValid is also high.
REQ-016 qCount  output  log2(DEPTH)+1  current number of queued entries.

Function
REQ-017 Internal pc register drives addr directly; addr SHALL equal pc at all times.
REQ-018 FSM states: FETCH (queue not full, address presented) and STALL (queue full, address held).
REQ-019 Accept condition: state FETCH, memReady=1, readValid=1, addrIn=={pc[31:2],2'b00}, redirect=0.
REQ-020 On accept, push {pc, din} at queue tail and set pc=pc+4 (32-bit wrap, 32'hFFFF_FFFC -> 32'h0000_0000) on the same edge.
REQ-021 Responses with addrIn not equal to pc are discarded; pc unchanged; no push.
REQ-022 Combinational memory gives one accept per cycle; sustained throughput is one instruction per clk.
REQ-023 Pop occurs when instValid=1 and instReady=1; head advances one entry on that edge.
REQ-024 Push requires count<DEPTH before the edge; simultaneous push and pop when not full leaves count unchanged, both take effect.
REQ-025 Push and pop in the same cycle when full: pop only, no push; FSM moves STALL->FETCH.
REQ-026 FETCH->STALL when an accepted push makes count equal DEPTH; STALL->FETCH on any pop.
REQ-027 In STALL addr held constant; readValid ignored.
REQ-028 redirect=1: queue emptied (count=0, instValid=0 next cycle), pc={redirectPc[31:2],2'b00}, state FETCH, any same-cycle response and pop discarded.
REQ-029 Redirect priority over accept, pop and STALL; back-to-back redirects, last one wins.
REQ-030 instData/instPc come from queue storage registers; instruction visible on instValid the cycle after its accept edge.
REQ-031 Queue pointers wrap modulo DEPTH; qCount ranges 0..DEPTH.
REQ-032 Queue storage contents need no reset; only valid-qualified outputs are meaningful.

Reset
REQ-033 While rst=1: pc=RESET_PC aligned, addr=RESET_PC aligned, count=0, instValid=0, qCount=0, state FETCH, instData=0, instPc=0.
REQ-034 rst asserted mid-operation discards all queued entries and any in-progress response immediately.
REQ-035 First accept possible on the first rising edge with rst=0.

Verification
REQ-036 Reset release, memory returns word at 0x00=32'h37010080 combinationally, instReady=1 -> instValid=1 next cycle, instPc=0x00, instData=32'h37010080, then 0x04,0x08,... one per cycle.
REQ-037 instReady=0 for 10 cycles, DEPTH=4 -> qCount reaches 4, addr holds 0x10, then instReady=1 drains 0x00..0x0C in order and fetch resumes at 0x10.
REQ-038 redirect=1 with redirectPc=32'h0000_0026 while queue holds 3 entries -> next cycle instValid=0, qCount=0, addr=0x24; following cycle instPc=0x24, instData=32'h83200100.
REQ-039 Memory returns addrIn=0x08 while pc=0x04 -> no push, pc stays 0x04 until matching response.
REQ-040 memReady=0 or readValid=0 for 3 cycles -> no pushes, addr constant; rst pulsed with 2 entries queued -> instValid=0 and addr=RESET_PC asynchronously.
REQ-041 pc=32'hFFFF_FFFC accepted -> next addr=32'h0000_0000, entry instPc=32'hFFFF_FFFC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch unit: presents a word-aligned PC to memory, queues {pc, data} responses whose address matches.
// Accept-to-head latency is 1 cycle. The unit stalls with the address held while the queue is full; redirect flushes the queue.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [31:0]              addr,
    input  logic [31:0]              din,
    input  logic [31:0]              addrIn,
    input  logic                     readValid,
    input  logic                     memReady,
    input  logic                     redirect,
    input  logic [31:0]              redirectPc,
    output logic                     instValid,
    output logic [31:0]              instData,
    output logic [31:0]              instPc,
    input  logic                     instReady,
    output logic [$clog2(DEPTH):0]   qCount
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [31:0] RESET_PC_A = {RESET_PC[31:2], 2'b00};
    localparam logic [PW:0] LAST_SLOT  = (PW+1)'(DEPTH - 1);

    typedef enum logic {FETCH, STALL} state_t;

    state_t         state;
    logic [31:0]    pc;
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;
    logic [PW:0]    count;
    logic [31:0]    pc_mem  [DEPTH];
    logic [31:0]    dat_mem [DEPTH];

    logic accept;
    logic full;
    logic push;
    logic pop;

    // DEPTH is a power of two, so the count MSB alone marks a full queue.
    assign full   = count[PW];
    assign accept = (state == FETCH) && memReady && readValid &&
                    (addrIn == {pc[31:2], 2'b00}) && !redirect;
    assign push   = accept && !full;
    assign pop    = (count != '0) && instReady && !redirect;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= FETCH;
            pc     <= RESET_PC_A;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect) begin
            state  <= FETCH;
            pc     <= redirectPc & 32'hFFFF_FFFC;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                pc     <= pc + 32'd4;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push && !pop && (count == LAST_SLOT)) begin
                state <= STALL;
            end else if (pop) begin
                state <= FETCH;
            end
        end
    end

    // Storage is deliberately left unreset; outputs below are qualified by instValid.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]  <= pc;
            dat_mem[wr_ptr] <= din;
        end
    end

    assign addr      = pc;
    assign instValid = (count != '0);
    assign instData  = instValid ? dat_mem[rd_ptr] : 32'h0;
    assign instPc    = instValid ? pc_mem[rd_ptr]  : 32'h0;
    assign qCount    = count;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed table and sequences plus randomized traffic against a queue-based reference model.
module tb_fetch_unit;
    localparam int DEPTH = 4;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic                    clk;
    logic                    rst;
    logic [31:0]             addr;
    logic [31:0]             din;
    logic [31:0]             addrIn;
    logic                    readValid;
    logic                    memReady;
    logic                    redirect;
    logic [31:0]             redirectPc;
    logic                    instValid;
    logic [31:0]             instData;
    logic [31:0]             instPc;
    logic                    instReady;
    logic [$clog2(DEPTH):0]  qCount;

    logic        use_echo;
    logic [31:0] forced_addr;

    int total = 0;
    int bad   = 0;

    fetch_unit #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .addr(addr), .din(din), .addrIn(addrIn),
        .readValid(readValid), .memReady(memReady), .redirect(redirect),
        .redirectPc(redirectPc), .instValid(instValid), .instData(instData),
        .instPc(instPc), .instReady(instReady), .qCount(qCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0000) return 32'h3701_0080;
        if (a == 32'h0000_0024) return 32'h8320_0100;
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    // Combinational memory: echoes the requested address unless the bench forces another.
    assign addrIn = use_echo ? addr : forced_addr;
    assign din    = mem_word(addrIn);

    // Reference model: a plain queue of fetched words and the next address to fetch.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] dat;
    } ent_t;
    ent_t        mq[$];
    logic [31:0] mpc;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            mpc = RPC & 32'hFFFF_FFFC;
        end else if (redirect) begin
            mq.delete();
            mpc = redirectPc & 32'hFFFF_FFFC;
        end else begin
            bit take;
            bit drop;
            ent_t e;
            take = (mq.size() < DEPTH) && memReady && readValid && (addrIn == mpc);
            drop = (mq.size() > 0) && instReady;
            e.pc  = mpc;
            e.dat = din;
            if (drop) void'(mq.pop_front());
            if (take) begin
                mq.push_back(e);
                mpc = mpc + 32'd4;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_model();
        chk("m_addr", addr, mpc);
        chk("m_valid", 32'(instValid), 32'(mq.size() > 0));
        chk("m_qcount", 32'(qCount), 32'(mq.size()));
        if (mq.size() > 0) begin
            chk("m_instpc", instPc, mq[0].pc);
            chk("m_instdata", instData, mq[0].dat);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cmp_model();
    endtask

    typedef struct {
        logic        rdy;
        logic [31:0] e_addr;
        int          e_cnt;
        logic [31:0] e_pc;
    } vec_t;
    vec_t tbl[14];

    initial begin
        // Stall-and-drain vectors starting from an empty queue at pc 0.
        for (int i = 0; i < 10; i++) begin
            tbl[i].rdy    = 1'b0;
            tbl[i].e_cnt  = (i < 4) ? i + 1 : 4;
            tbl[i].e_addr = (i < 4) ? 32'(4 * (i + 1)) : 32'h10;
            tbl[i].e_pc   = 32'h0;
        end
        tbl[10] = '{1'b1, 32'h10, 3, 32'h04};
        tbl[11] = '{1'b1, 32'h14, 3, 32'h08};
        tbl[12] = '{1'b1, 32'h18, 3, 32'h0C};
        tbl[13] = '{1'b1, 32'h1C, 3, 32'h10};

        rst = 1'b1; memReady = 1'b1; readValid = 1'b1; use_echo = 1'b1;
        forced_addr = 32'h0; instReady = 1'b0; redirect = 1'b0; redirectPc = 32'h0;
        #7;
        chk("rst_addr", addr, RPC);
        chk("rst_valid", 32'(instValid), 32'h0);
        chk("rst_qcount", 32'(qCount), 32'h0);
        chk("rst_data", instData, 32'h0);
        chk("rst_pc", instPc, 32'h0);

        // Streaming after reset release: one instruction per clock.
        instReady = 1'b1;
        #1 rst = 1'b0;
        tick();
        chk("s_valid", 32'(instValid), 32'h1);
        chk("s_pc0", instPc, 32'h0);
        chk("s_data0", instData, 32'h3701_0080);
        tick();
        chk("s_pc1", instPc, 32'h4);
        tick();
        chk("s_pc2", instPc, 32'h8);

        redirect = 1'b1; redirectPc = 32'h0; instReady = 1'b0;
        tick();
        redirect = 1'b0;
        for (int i = 0; i < 14; i++) begin
            instReady = tbl[i].rdy;
            tick();
            chk("t_addr", addr, tbl[i].e_addr);
            chk("t_qcount", 32'(qCount), 32'(tbl[i].e_cnt));
            chk("t_instpc", instPc, tbl[i].e_pc);
        end

        // Redirect with three queued entries, misaligned target.
        redirect = 1'b1; redirectPc = 32'h0000_0026; instReady = 1'b0;
        tick();
        chk("r_valid", 32'(instValid), 32'h0);
        chk("r_qcount", 32'(qCount), 32'h0);
        chk("r_addr", addr, 32'h24);
        redirect = 1'b0;
        tick();
        chk("r_valid2", 32'(instValid), 32'h1);
        chk("r_instpc", instPc, 32'h24);
        chk("r_data", instData, 32'h8320_0100);

        // Mismatched echoed address is discarded.
        redirect = 1'b1; redirectPc = 32'h4; memReady = 1'b0;
        tick();
        redirect = 1'b0; memReady = 1'b1; use_echo = 1'b0; forced_addr = 32'h8;
        tick();
        tick();
        chk("x_addr", addr, 32'h4);
        chk("x_qcount", 32'(qCount), 32'h0);
        use_echo = 1'b1;
        tick();
        chk("x_qcount2", 32'(qCount), 32'h1);
        chk("x_instpc", instPc, 32'h4);

        // No traffic while memReady or readValid is low.
        memReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("n_addr_mr", addr, 32'h8);
        end
        memReady = 1'b1; readValid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("n_addr_rv", addr, 32'h8);
        end
        readValid = 1'b1;
        tick();
        chk("n_qcount", 32'(qCount), 32'h2);

        // Asynchronous reset between edges.
        #2 rst = 1'b1;
        #1;
        chk("a_valid", 32'(instValid), 32'h0);
        chk("a_addr", addr, RPC);
        chk("a_qcount", 32'(qCount), 32'h0);
        #2 rst = 1'b0;
        tick();

        // Address wrap at the top of memory.
        redirect = 1'b1; redirectPc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        tick();
        chk("w_addr", addr, 32'h0);
        chk("w_instpc", instPc, 32'hFFFF_FFFC);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            memReady    = ($urandom_range(0, 3) != 0);
            readValid   = ($urandom_range(0, 3) != 0);
            instReady   = ($urandom_range(0, 2) != 0);
            use_echo    = ($urandom_range(0, 7) != 0);
            forced_addr = ($urandom_range(0, 1) != 0) ? addr + 32'(4 * $urandom_range(1, 3))
                                                       : $urandom();
            redirect    = ($urandom_range(0, 31) == 0);
            redirectPc  = $urandom();
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
